fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Drain engine for the accelerator's FIFO buffer. It issues pops on the FIFO's read side and re-times the returned words onto a valid/ready stream for downstream accelerator datapaths.
- A burst of i_len words is started by a one-cycle i_start pulse. o_last marks the final word, and o_done pulses when the burst completes.
- It handles the FIFO's one-cycle read latency with a 3-entry skid buffer, so it sustains one word per cycle with no combinational path from i_ready to the FIFO.

Parameters:
- DATA_SIZE, 16, word width; must match the FIFO's DATA_SIZE.
- BURST_MAX, 256, largest legal burst length.
- CNT_SIZE, $clog2(BURST_MAX+1), width of the length and beat counters.

Ports:
- i_clk  input  1  clock.
- i_reset_n  input  1  asynchronous active-low reset.
- i_start  input  1  burst start pulse; sampled only in IDLE.
- i_len  input  CNT_SIZE  burst length in words; sampled with i_start.
- o_busy  output  1  high from the cycle after an accepted start until the cycle o_done pulses.
- o_done  output  1  one-cycle completion pulse.
- o_fifo_en  output  1  FIFO enable; high in RUN, low otherwise.
- o_fifo_read  output  1  FIFO pop request.
- i_fifo_data  input  DATA_SIZE  FIFO read data; valid the cycle after an accepted pop.
- i_fifo_empty  input  1  FIFO empty flag.
- o_data  output  DATA_SIZE  stream data.
- o_valid  output  1  stream valid.
- i_ready  input  1  stream ready.
- o_last  output  1  qualifies the final word of the burst.

Behaviour:
- Reset: asynchronous, active-low.
  - State goes to IDLE; all counters and skid entries are cleared.
  - o_busy, o_done, o_fifo_en, o_fifo_read, o_valid and o_last are 0; o_data is 0.
  - Reset mid-burst discards in-flight and buffered words; no o_done is produced.
- IDLE:
  - i_start=1 with i_len!=0: load reads_left=i_len and beats_left=i_len, go to RUN.
  - i_start=1 with i_len==0: go to DONE directly; no FIFO access.
- RUN:
  - Pop rule: o_fifo_read = (reads_left!=0) && !i_fifo_empty && (occ+inflight < 3).
    - occ is the number of skid entries held (0..3).
    - inflight is 1 if a pop was issued in the previous cycle.
  - On each cycle with o_fifo_read=1, reads_left decrements.
  - The cycle after a pop, i_fifo_data is captured into the skid tail and occ increments.
  - Handshake: a word transfers when o_valid && i_ready.
    - o_valid = (occ!=0).
    - o_data and o_last come from the skid head.
    - o_last = (beats_left==1).
    - On transfer, beats_left decrements and occ decrements.
  - Capture and transfer in the same cycle leave occ unchanged and preserve order.
  - Once o_valid=1, o_data and o_last hold stable until transfer.
  - On the transfer with o_last=1, go to DONE.
- DONE: o_done=1 for exactly one cycle, o_busy=0, then IDLE. A new i_start is accepted the cycle after DONE.
- i_start while not in IDLE is ignored.
- Empty FIFO: no pop is issued and no stall error is raised; the burst waits indefinitely.
- Occupancy bound: the skid never exceeds 3; a capture into a full skid is impossible by the pop rule.
- Throughput: with i_ready=1 and a non-empty FIFO, o_valid stays high every cycle from RUN cycle 3 (start+3) to the end of the burst.
- Widths:
  - Counters are CNT_SIZE wide and never underflow.
  - i_len > BURST_MAX is illegal; behaviour is undefined, and an assertion flags it.

Decomposition:
- Package fifo_burst_reader_pkg:
  - typedef enum {IDLE, RUN, DONE} state type.
  - Constant SKID_DEPTH = 3.
- One sub-module: fifo_burst_reader_skid.
  - 3-entry register FIFO with push/pop/occ.
  - Parameterised by DATA_SIZE.
  - Holds both data and the pop-order index; o_last stays derived in the parent.

Test Plan:
- Basic burst: FIFO preloaded with 0x1111..0x5555, i_len=5, i_ready=1 -> 5 pops; o_data 0x1111..0x5555 on consecutive cycles; o_last only on 0x5555; o_done one cycle later; o_busy low with o_done.
- Backpressure: i_len=8, i_ready toggling 1,0,0,1 pattern -> data order preserved; o_data stable while o_valid && !i_ready; o_fifo_read never asserted when occ+inflight=3.
- Empty stall: FIFO holds 2 words, i_len=4; push 2 more after 10 cycles -> reader stalls with o_valid=0; resumes and delivers all 4 words; exactly 4 pops total.
- Zero length and start-while-busy: i_len=0 -> o_done next cycle with no pop; i_start pulsed mid-burst with i_len=3 -> ignored; only the original burst count completes.
- Reset mid-operation: assert i_reset_n=0 after 3 of 6 beats -> all outputs 0 asynchronously; no o_done; after release, a new burst of 2 delivers the next 2 FIFO words correctly.

Source files
------------

// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO burst reader.
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         SKID_DEPTH = 3;
    localparam logic [1:0] SKID_FULL  = 2'(SKID_DEPTH);

endpackage

// File: rtl/fifo_burst_reader_skid.sv
// Three-entry register FIFO that absorbs the FIFO read latency.
// Entry 0 is always the head; unused entries are kept at zero so the
// head reads as zero whenever the buffer is empty.
module fifo_burst_reader_skid
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int IDX_SIZE  = 9
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_push,
    input  logic [DATA_SIZE-1:0] i_push_data,
    input  logic [IDX_SIZE-1:0]  i_push_idx,
    input  logic                 i_pop,
    output logic [DATA_SIZE-1:0] o_head_data,
    output logic [IDX_SIZE-1:0]  o_head_idx,
    output logic [1:0]           o_occ
);

    logic [DATA_SIZE-1:0] data_q [SKID_DEPTH];
    logic [IDX_SIZE-1:0]  idx_q  [SKID_DEPTH];
    logic [1:0]           occ_q;
    logic [1:0]           wr_pos;
    logic                 pop_eff;
    logic                 push_ok;

    // A simultaneous pop shifts the queue down, so the new word lands one slot lower.
    assign pop_eff = i_pop && (occ_q != 2'd0);
    assign wr_pos  = pop_eff ? (occ_q - 2'd1) : occ_q;
    assign push_ok = i_push && (wr_pos < SKID_FULL);

    assign o_head_data = data_q[0];
    assign o_head_idx  = idx_q[0];
    assign o_occ       = occ_q;

    // Shift-down storage with tail write; the later push write wins over the shift.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                data_q[i] <= '0;
                idx_q[i]  <= '0;
            end
            occ_q <= '0;
        end else begin
            if (pop_eff) begin
                for (int i = 0; i < SKID_DEPTH - 1; i++) begin
                    data_q[i] <= data_q[i+1];
                    idx_q[i]  <= idx_q[i+1];
                end
                data_q[SKID_DEPTH-1] <= '0;
                idx_q[SKID_DEPTH-1]  <= '0;
            end
            if (push_ok) begin
                data_q[wr_pos] <= i_push_data;
                idx_q[wr_pos]  <= i_push_idx;
            end
            occ_q <= occ_q + {1'b0, push_ok} - {1'b0, pop_eff};
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a burst of words from the accelerator FIFO onto a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for i_start
// RUN   | popping the FIFO and streaming words out
// DONE  | one-cycle completion pulse, then back to IDLE
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int BURST_MAX = 256,
    parameter int CNT_SIZE  = $clog2(BURST_MAX + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic [CNT_SIZE-1:0]  i_len,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_fifo_en,
    output logic                 o_fifo_read,
    input  logic [DATA_SIZE-1:0] i_fifo_data,
    input  logic                 i_fifo_empty,
    output logic [DATA_SIZE-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_last
);

    state_t              state_q;
    logic [CNT_SIZE-1:0] reads_left_q;
    logic [CNT_SIZE-1:0] beats_left_q;
    logic [CNT_SIZE-1:0] len_q;
    logic [CNT_SIZE-1:0] cap_idx_q;
    logic                inflight_q;
    logic                busy_q;
    logic                done_q;
    logic                fifo_en_q;
    logic [1:0]          occ;
    logic [CNT_SIZE-1:0] head_idx;
    logic [2:0]          pending;
    logic                pop_req;
    logic                xfer;

    // Words already held plus the one still in the FIFO pipeline must fit in the skid.
    assign pending = {1'b0, occ} + {2'b00, inflight_q};
    assign pop_req = (state_q == RUN) && (reads_left_q != '0) && !i_fifo_empty
                     && (pending < 3'(SKID_DEPTH));

    assign o_valid     = (occ != 2'd0);
    assign xfer        = o_valid && i_ready;
    assign o_last      = o_valid && (beats_left_q == CNT_SIZE'(1));
    assign o_fifo_read = pop_req;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_fifo_en   = fifo_en_q;

    fifo_burst_reader_skid #(
        .DATA_SIZE (DATA_SIZE),
        .IDX_SIZE  (CNT_SIZE)
    ) u_skid (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_push      (inflight_q),
        .i_push_data (i_fifo_data),
        .i_push_idx  (cap_idx_q),
        .i_pop       (xfer),
        .o_head_data (o_data),
        .o_head_idx  (head_idx),
        .o_occ       (occ)
    );

    // Burst sequencing, down-counters and registered status outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            reads_left_q <= '0;
            beats_left_q <= '0;
            len_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fifo_en_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        if (i_len != '0) begin
                            reads_left_q <= i_len;
                            beats_left_q <= i_len;
                            len_q        <= i_len;
                            busy_q       <= 1'b1;
                            fifo_en_q    <= 1'b1;
                            state_q      <= RUN;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (pop_req) begin
                        reads_left_q <= reads_left_q - CNT_SIZE'(1);
                    end
                    if (xfer) begin
                        beats_left_q <= beats_left_q - CNT_SIZE'(1);
                        if (beats_left_q == CNT_SIZE'(1)) begin
                            busy_q    <= 1'b0;
                            fifo_en_q <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q    <= 1'b0;
                    fifo_en_q <= 1'b0;
                    done_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // Track the FIFO's one-cycle read latency and tag each captured word with its order.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            inflight_q <= 1'b0;
            cap_idx_q  <= '0;
        end else begin
            inflight_q <= pop_req;
            if (state_q == IDLE) begin
                cap_idx_q <= '0;
            end else if (inflight_q) begin
                cap_idx_q <= cap_idx_q + CNT_SIZE'(1);
            end
        end
    end

    a_len_legal: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (state_q == IDLE && i_start) |-> (i_len <= CNT_SIZE'(BURST_MAX)));

    a_skid_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        inflight_q |-> (occ != SKID_FULL));

    a_skid_order: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        o_valid |-> (head_idx == (len_q - beats_left_q)));

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

    localparam int DATA_SIZE = 16;
    localparam int CNT_SIZE  = 9;

    logic                 i_clk = 1'b0;
    logic                 i_reset_n = 1'b0;
    logic                 i_start = 1'b0;
    logic [CNT_SIZE-1:0]  i_len = '0;
    logic                 i_ready = 1'b0;
    logic                 o_busy, o_done, o_fifo_en, o_fifo_read, o_valid, o_last;
    logic [DATA_SIZE-1:0] o_data;

    logic                 fifo_empty = 1'b1;
    logic [DATA_SIZE-1:0] fifo_rdata = '0;
    logic                 push_en = 1'b0;
    logic [DATA_SIZE-1:0] push_word = '0;
    logic [DATA_SIZE-1:0] mem[$];
    logic [DATA_SIZE-1:0] exp_q[$];
    int                   pop_cnt = 0;
    int                   underflow_cnt = 0;
    int                   checks = 0;
    int                   failures = 0;

    always #5 i_clk = ~i_clk;

    fifo_burst_reader dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_start      (i_start),
        .i_len        (i_len),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_fifo_en    (o_fifo_en),
        .o_fifo_read  (o_fifo_read),
        .i_fifo_data  (fifo_rdata),
        .i_fifo_empty (fifo_empty),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_last       (o_last)
    );

    // Behavioural FIFO with one-cycle read latency
    always @(posedge i_clk) begin
        if (o_fifo_read) begin
            pop_cnt++;
            if (mem.size() == 0) underflow_cnt++;
            else fifo_rdata <= mem.pop_front();
        end
        if (push_en) mem.push_back(push_word);
        fifo_empty <= (mem.size() == 0);
    end

    task automatic load_seq(input logic [DATA_SIZE-1:0] base, input int n,
                            input logic [DATA_SIZE-1:0] step);
        logic [DATA_SIZE-1:0] w;
        w = base;
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            push_en = 1'b1;
            push_word = w;
            exp_q.push_back(w);
            w = w + step;
        end
        @(negedge i_clk);
        push_en = 1'b0;
    endtask

    // Returns at the first negedge after the start edge
    task automatic start_burst(input int len);
        @(negedge i_clk);
        i_start = 1'b1;
        i_len = CNT_SIZE'(len);
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", o_done); end
        checks++; if (o_fifo_en !== 1'b0) begin failures++; $display("FAIL reset_fifo_en: got %b expected 0", o_fifo_en); end
        checks++; if (o_fifo_read !== 1'b0) begin failures++; $display("FAIL reset_fifo_read: got %b expected 0", o_fifo_read); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        checks++; if (o_last !== 1'b0) begin failures++; $display("FAIL reset_last: got %b expected 0", o_last); end
        checks++; if (o_data !== 16'h0) begin failures++; $display("FAIL reset_data: got %h expected 0000", o_data); end
        i_reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int p0, first_k, last_k, done_k, nx, beats;
        logic [DATA_SIZE-1:0] e;
        load_seq(16'h1111, 5, 16'h1111);
        p0 = pop_cnt; first_k = -1; last_k = -1; done_k = -1; nx = 0; beats = 5;
        i_ready = 1'b1;
        start_burst(5);
        for (int k = 0; k < 40 && done_k < 0; k++) begin
            if (o_valid && first_k < 0) first_k = k;
            if (o_valid && i_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++; if (o_data !== e) begin failures++; $display("FAIL basic_data: got %h expected %h", o_data, e); end
                checks++; if (o_last !== (beats == 1)) begin failures++; $display("FAIL basic_last: got %b expected %b", o_last, beats == 1); end
                beats--; nx++; last_k = k;
            end
            if (o_done) begin
                done_k = k;
                checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done: got %b expected 0", o_busy); end
            end else if (o_busy !== 1'b1 || o_fifo_en !== 1'b1) begin
                checks++; failures++;
                $display("FAIL basic_busy_run: got busy=%b en=%b expected 1", o_busy, o_fifo_en);
            end
            @(negedge i_clk);
        end
        checks++; if (first_k !== 2) begin failures++; $display("FAIL basic_first_valid: got cycle %0d expected 2", first_k); end
        checks++; if (nx !== 5 || last_k !== 6) begin failures++; $display("FAIL basic_count: got %0d words ending %0d expected 5 ending 6", nx, last_k); end
        checks++; if (done_k !== 7) begin failures++; $display("FAIL basic_done_cycle: got %0d expected 7", done_k); end
        checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: got %b expected 0", o_done); end
        checks++; if (pop_cnt - p0 !== 5) begin failures++; $display("FAIL basic_pops: got %0d expected 5", pop_cnt - p0); end
    endtask

    task automatic test_backpressure();
        int p0, done_k, nx, beats, occ_m, infl_m;
        logic hold_v, hold_l;
        logic [DATA_SIZE-1:0] hold_d, e;
        load_seq(16'hA001, 8, 16'h0101);
        p0 = pop_cnt; done_k = -1; nx = 0; beats = 8; occ_m = 0; infl_m = 0; hold_v = 0;
        hold_d = '0; hold_l = 1'b0;
        i_ready = 1'b1;
        start_burst(8);
        for (int k = 0; k < 120 && done_k < 0; k++) begin
            i_ready = ((k % 4) == 0) || ((k % 4) == 3);
            checks++; if (o_valid !== (occ_m != 0)) begin failures++; $display("FAIL bp_valid: got %b expected %b at %0d", o_valid, occ_m != 0, k); end
            if (occ_m + infl_m == 3) begin
                checks++; if (o_fifo_read !== 1'b0) begin failures++; $display("FAIL bp_read_when_full: got %b expected 0 at %0d", o_fifo_read, k); end
            end
            if (hold_v) begin
                checks++;
                if (o_valid !== 1'b1 || o_data !== hold_d || o_last !== hold_l) begin
                    failures++;
                    $display("FAIL bp_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b", o_valid, o_data, o_last, hold_d, hold_l);
                end
            end
            if (o_valid && i_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++; if (o_data !== e) begin failures++; $display("FAIL bp_data: got %h expected %h", o_data, e); end
                checks++; if (o_last !== (beats == 1)) begin failures++; $display("FAIL bp_last: got %b expected %b", o_last, beats == 1); end
                beats--; nx++;
            end
            if (o_done) done_k = k;
            hold_v = o_valid && !i_ready; hold_d = o_data; hold_l = o_last;
            occ_m = occ_m + infl_m - ((o_valid && i_ready) ? 1 : 0);
            infl_m = o_fifo_read ? 1 : 0;
            @(negedge i_clk);
        end
        i_ready = 1'b1;
        checks++; if (done_k < 0 || nx !== 8) begin failures++; $display("FAIL bp_complete: got %0d words done=%0d expected 8 words and done", nx, done_k); end
        checks++; if (pop_cnt - p0 !== 8) begin failures++; $display("FAIL bp_pops: got %0d expected 8", pop_cnt - p0); end
        checks++; if (underflow_cnt !== 0) begin failures++; $display("FAIL bp_underflow: got %0d expected 0", underflow_cnt); end
    endtask

    task automatic test_empty_stall();
        int p0, done_k, nx;
        logic [DATA_SIZE-1:0] e;
        load_seq(16'hB001, 2, 16'h0001);
        p0 = pop_cnt; done_k = -1; nx = 0;
        i_ready = 1'b1;
        start_burst(4);
        for (int k = 0; k < 60 && done_k < 0; k++) begin
            push_en = (k == 10) || (k == 11);
            push_word = (k == 10) ? 16'hB003 : 16'hB004;
            if (push_en) exp_q.push_back(push_word);
            if (k == 9) begin
                checks++; if (o_valid !== 1'b0 || o_busy !== 1'b1) begin failures++; $display("FAIL stall_wait: got valid=%b busy=%b expected 0/1", o_valid, o_busy); end
            end
            if (o_valid && i_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++; if (o_data !== e) begin failures++; $display("FAIL stall_data: got %h expected %h", o_data, e); end
                checks++; if (o_last !== (nx == 3)) begin failures++; $display("FAIL stall_last: got %b expected %b", o_last, nx == 3); end
                nx++;
            end
            if (o_done) done_k = k;
            @(negedge i_clk);
        end
        push_en = 1'b0;
        checks++; if (done_k < 0 || nx !== 4) begin failures++; $display("FAIL stall_complete: got %0d words done=%0d expected 4 words and done", nx, done_k); end
        checks++; if (pop_cnt - p0 !== 4) begin failures++; $display("FAIL stall_pops: got %0d expected 4", pop_cnt - p0); end
    endtask

    task automatic test_zero_and_busy();
        int p0, dones, nx;
        logic [DATA_SIZE-1:0] e;
        p0 = pop_cnt;
        start_burst(0);
        checks++; if (o_done !== 1'b1 || o_busy !== 1'b0 || o_fifo_en !== 1'b0) begin failures++; $display("FAIL zero_done: got done=%b busy=%b en=%b expected 1/0/0", o_done, o_busy, o_fifo_en); end
        @(negedge i_clk);
        checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL zero_pulse: got %b expected 0", o_done); end
        i_start = 1'b1;
        i_len = '0;
        @(negedge i_clk);
        i_start = 1'b0;
        checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL zero_back_to_back: got %b expected 1", o_done); end
        @(negedge i_clk);
        checks++; if (pop_cnt - p0 !== 0) begin failures++; $display("FAIL zero_pops: got %0d expected 0", pop_cnt - p0); end

        load_seq(16'hD001, 4, 16'h0011);
        p0 = pop_cnt; dones = 0; nx = 0;
        i_ready = 1'b1;
        start_burst(4);
        for (int k = 0; k < 40; k++) begin
            i_start = (k == 3);
            i_len = CNT_SIZE'(3);
            if (o_valid && i_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++; if (o_data !== e) begin failures++; $display("FAIL busy_data: got %h expected %h", o_data, e); end
                nx++;
            end
            if (o_done) dones++;
            @(negedge i_clk);
        end
        i_start = 1'b0;
        checks++; if (dones !== 1 || nx !== 4) begin failures++; $display("FAIL busy_ignored: got %0d dones %0d words expected 1 and 4", dones, nx); end
        checks++; if (pop_cnt - p0 !== 4) begin failures++; $display("FAIL busy_pops: got %0d expected 4", pop_cnt - p0); end
    endtask

    task automatic test_reset_mid();
        int p0, nx, done_k, seen_done;
        logic [DATA_SIZE-1:0] e;
        load_seq(16'hC001, 8, 16'h0001);
        nx = 0; seen_done = 0;
        i_ready = 1'b1;
        start_burst(6);
        for (int k = 0; k < 40 && nx < 3; k++) begin
            if (o_valid && i_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++; if (o_data !== e) begin failures++; $display("FAIL rst_pre_data: got %h expected %h", o_data, e); end
                nx++;
            end
            if (nx < 3) @(negedge i_clk);
        end
        checks++; if (nx !== 3) begin failures++; $display("FAIL rst_pre_count: got %0d expected 3", nx); end
        @(posedge i_clk);
        #2;
        i_reset_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_done, o_fifo_en, o_fifo_read, o_valid, o_last} !== 6'b0 || o_data !== 16'h0) begin
            failures++;
            $display("FAIL rst_async: got busy=%b done=%b en=%b rd=%b v=%b l=%b d=%h expected all 0",
                     o_busy, o_done, o_fifo_en, o_fifo_read, o_valid, o_last, o_data);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            if (o_done) seen_done++;
        end
        i_reset_n = 1'b1;
        @(negedge i_clk);
        if (o_done) seen_done++;
        checks++; if (seen_done !== 0) begin failures++; $display("FAIL rst_no_done: got %0d pulses expected 0", seen_done); end
        exp_q.delete();
        foreach (mem[i]) exp_q.push_back(mem[i]);
        p0 = pop_cnt; nx = 0; done_k = -1;
        start_burst(2);
        for (int k = 0; k < 40 && done_k < 0; k++) begin
            if (o_valid && i_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++; if (o_data !== e) begin failures++; $display("FAIL rst_post_data: got %h expected %h", o_data, e); end
                checks++; if (o_last !== (nx == 1)) begin failures++; $display("FAIL rst_post_last: got %b expected %b", o_last, nx == 1); end
                nx++;
            end
            if (o_done) done_k = k;
            @(negedge i_clk);
        end
        checks++; if (done_k < 0 || nx !== 2) begin failures++; $display("FAIL rst_post_complete: got %0d words done=%0d expected 2 and done", nx, done_k); end
        checks++; if (pop_cnt - p0 !== 2) begin failures++; $display("FAIL rst_post_pops: got %0d expected 2", pop_cnt - p0); end
        checks++; if (underflow_cnt !== 0) begin failures++; $display("FAIL fifo_underflow: got %0d expected 0", underflow_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty_stall();
        test_zero_and_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
